// File: rtl/sysbus_mem_responder_if.sv
// Sysbus line-transfer channel between an initiator (master) and a responder (slave).
// Signals: req/reqtag/reqcyc/reqack request beats; resp/resptag/respcyc/respack response beats.
interface sysbus_mem_responder_if #(
    parameter int TAG_W = 16
);
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqcyc;
    logic             reqack;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respcyc;
    logic             respack;

    modport master (
        output req, reqtag, reqcyc, respack,
        input  reqack, resp, resptag, respcyc
    );

    modport slave (
        input  req, reqtag, reqcyc, respack,
        output reqack, resp, resptag, respcyc
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: 64-byte line reads/writes into a 64-bit word store.
// Ports: clk, reset (sync, active-high), bus (slave side), busy, addr_err pulse.
module sysbus_mem_responder #(
    parameter int MEM_WORDS = 8192,
    parameter int LATENCY   = 4,
    parameter int TAG_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    sysbus_mem_responder_if.slave bus,
    output logic                 busy,
    output logic                 addr_err
);
    localparam int AW    = $clog2(MEM_WORDS);
    localparam int LW    = AW - 3;
    localparam int LINES = MEM_WORDS / 8;
    localparam logic [57:0] LINES_W  = 58'(LINES);
    localparam logic [7:0]  LAT_LAST = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WDATA,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [63:0]      mem [MEM_WORDS];
    logic [LW-1:0]    line_q;
    logic             oob_q;
    logic             wr_q;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       beat_cnt;
    logic [7:0]       lat_cnt;
    logic [63:0]      resp_q;

    logic       acc;
    logic       retire;
    logic       req_oob;
    logic       lat_done;
    logic       last_beat;
    logic [2:0] beat_nxt;
    logic       unused_ok;

    assign acc       = bus.reqcyc & bus.reqack;
    assign retire    = bus.respcyc & bus.respack;
    assign req_oob   = bus.req[63:6] >= LINES_W;
    assign lat_done  = lat_cnt == LAT_LAST;
    assign last_beat = beat_cnt == 3'd7;
    assign beat_nxt  = beat_cnt + 3'd1;
    assign unused_ok = ^bus.req[5:0];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (acc)
                    state_nxt = bus.reqtag[12] ? S_WDATA : S_WAIT;
            S_WDATA:
                if (acc && last_beat) state_nxt = S_WAIT;
            S_WAIT:
                if (lat_done) state_nxt = S_RESP;
            S_RESP:
                if (retire && (wr_q || last_beat))
                    state_nxt = S_IDLE;
        endcase
    end

    // reqack is withheld during reset so a beat is never
    // acknowledged in a cycle that the abort discards.
    always_comb begin
        bus.reqack  = 1'b0;
        bus.respcyc = 1'b0;
        bus.resptag = '0;
        busy        = 1'b1;
        unique case (state)
            S_IDLE: begin
                bus.reqack = bus.reqcyc & ~reset;
                busy       = 1'b0;
            end
            S_WDATA: bus.reqack = bus.reqcyc & ~reset;
            S_WAIT:  ;
            S_RESP: begin
                bus.respcyc = 1'b1;
                bus.resptag = tag_q;
            end
        endcase
    end

    assign bus.resp = resp_q;

    // resp_q is loaded one word ahead so the presented beat
    // stays stable until the initiator acks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_q   <= '0;
            oob_q    <= 1'b0;
            wr_q     <= 1'b0;
            tag_q    <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            resp_q   <= '0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            unique case (state)
                S_IDLE:
                    if (acc) begin
                        line_q   <= bus.req[6 +: LW];
                        oob_q    <= req_oob;
                        wr_q     <= bus.reqtag[12];
                        tag_q    <= bus.reqtag;
                        addr_err <= req_oob;
                        beat_cnt <= '0;
                        lat_cnt  <= '0;
                    end
                S_WDATA:
                    if (acc) begin
                        beat_cnt <= beat_nxt;
                        lat_cnt  <= '0;
                    end
                S_WAIT: begin
                    lat_cnt <= lat_cnt + 8'd1;
                    if (lat_done) begin
                        beat_cnt <= '0;
                        resp_q   <= (wr_q || oob_q) ? '0 :
                                    mem[{line_q, 3'd0}];
                    end
                end
                S_RESP:
                    if (retire) begin
                        beat_cnt <= beat_nxt;
                        if (wr_q || last_beat || oob_q)
                            resp_q <= '0;
                        else
                            resp_q <= mem[{line_q, beat_nxt}];
                    end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_WDATA && acc && !oob_q)
            mem[{line_q, beat_cnt}] <= bus.req;
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Self-checking bench for sysbus_mem_responder: vector table,
// hand-written corner sequences and randomized ops against a word-array model.
module tb_sysbus_mem_responder;
    localparam int MEM_WORDS = 8192;
    localparam int LATENCY   = 4;
    localparam int TAG_W     = 16;
    localparam int LINES     = MEM_WORDS / 8;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic addr_err;

    sysbus_mem_responder_if #(.TAG_W(TAG_W)) bus ();

    sysbus_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .LATENCY  (LATENCY),
        .TAG_W    (TAG_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    logic [63:0] wd [8];
    logic [63:0] ed [8];
    logic [63:0] mdl [int];

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [15:0] tag;
        logic [63:0] base;
        int          mode;
        bit          err;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_beat(input logic [63:0] d,
                             input logic [TAG_W-1:0] t);
        int n = 0;
        bus.req    = d;
        bus.reqtag = t;
        bus.reqcyc = 1'b1;
        #1;
        while (!bus.reqack && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.reqack) chk("reqack_timeout", 64'(bus.reqack), 64'd1);
        @(negedge clk);
        bus.reqcyc = 1'b0;
    endtask

    task automatic collect(input int nb, input logic [TAG_W-1:0] tag,
                           input int mode, input bit chk_lat,
                           input bit hold_req);
        int k = 0;
        int got = 0;
        int cyc = 0;
        int ph = 0;
        bit ack;
        while (!bus.respcyc && k < 400) begin
            if (hold_req) chk("reqack_held", 64'(bus.reqack), 64'd0);
            bus.respack = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            k++;
            chk("addr_err_once", 64'(addr_err), 64'd0);
        end
        if (!bus.respcyc) begin
            chk("resp_timeout", 64'(bus.respcyc), 64'd1);
            bus.respack = 1'b0;
            return;
        end
        if (chk_lat) chk("latency", 64'(k), 64'(LATENCY));
        while (got < nb && cyc < 400) begin
            chk("resp", bus.resp, ed[got]);
            chk("resptag", 64'(bus.resptag), 64'(tag));
            chk("respcyc", 64'(bus.respcyc), 64'd1);
            if (hold_req) chk("reqack_held", 64'(bus.reqack), 64'd0);
            case (mode)
                0:       ack = 1'b1;
                1:       ack = (ph % 3) == 0;
                default: ack = 1'($urandom_range(0, 1));
            endcase
            ph++;
            bus.respack = ack;
            @(negedge clk);
            cyc++;
            if (ack) got++;
        end
        bus.respack = 1'b0;
        chk("respcyc_end", 64'(bus.respcyc), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    task automatic do_op(input bit wr, input logic [63:0] addr,
                         input logic [TAG_W-1:0] tag, input int mode,
                         input bit err);
        logic [57:0] ln;
        ln = addr[63:6];
        send_beat(addr, tag);
        chk("addr_err", 64'(addr_err), 64'(err));
        if (wr) begin
            for (int i = 0; i < 8; i++) send_beat(wd[i], tag);
            if (!err)
                for (int i = 0; i < 8; i++) mdl[int'(ln) * 8 + i] = wd[i];
            ed[0] = '0;
            collect(1, tag, mode, 1'b0, 1'b0);
        end else begin
            collect(8, tag, mode, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] oob_addr;
        logic [63:0] last_addr;
        oob_addr  = 64'(MEM_WORDS) * 64'd8;
        last_addr = 64'(LINES - 1) * 64'd64;

        tbl[0]  = '{1, 64'h0,    16'h1001, 64'h3300,   0, 0};
        tbl[1]  = '{1, 64'h200,  16'h1000, 64'h1000,   0, 0};
        tbl[2]  = '{0, 64'h200,  16'h0007, 64'h1000,   0, 0};
        tbl[3]  = '{1, 64'h1C0,  16'h1003, 64'hA0,     0, 0};
        tbl[4]  = '{0, 64'h1C5,  16'h0005, 64'hA0,     0, 0};
        tbl[5]  = '{0, 64'h200,  16'h0042, 64'h1000,   1, 0};
        tbl[6]  = '{0, oob_addr, 16'h0009, 64'h0,      0, 1};
        tbl[7]  = '{1, oob_addr, 16'h1009, 64'hDEAD00, 0, 1};
        tbl[8]  = '{0, 64'h0,    16'h000B, 64'h3300,   2, 0};
        tbl[9]  = '{1, last_addr, 16'h100C, 64'h5500,  0, 0};
        tbl[10] = '{0, last_addr + 64'h3F, 16'h000D, 64'h5500, 0, 0};
        tbl[11] = '{0, 64'hFFFF_FFFF_FFFF_FFC0, 16'h000E, 64'h0, 0, 1};
        tbl[12] = '{0, 64'h1C0,  16'h000F, 64'hA0,     1, 0};

        reset       = 1'b1;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.reqcyc  = 1'b0;
        bus.respack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_respcyc", 64'(bus.respcyc), 64'd0);
        chk("rst_resp", bus.resp, 64'd0);
        chk("rst_resptag", 64'(bus.resptag), 64'd0);
        chk("rst_addr_err", 64'(addr_err), 64'd0);
        chk("rst_reqack", 64'(bus.reqack), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 13; v++) begin
            for (int i = 0; i < 8; i++) begin
                wd[i] = tbl[v].base + 64'(i);
                ed[i] = tbl[v].err ? 64'd0 : tbl[v].base + 64'(i);
            end
            do_op(tbl[v].wr, tbl[v].addr, tbl[v].tag,
                  tbl[v].mode, tbl[v].err);
        end

        // request held high across a prior read's response
        for (int i = 0; i < 8; i++) ed[i] = 64'h1000 + 64'(i);
        send_beat(64'h200, 16'h0021);
        bus.req    = 64'h1C0;
        bus.reqtag = 16'h0022;
        bus.reqcyc = 1'b1;
        collect(8, 16'h0021, 0, 1'b1, 1'b1);
        chk("reqack_idle", 64'(bus.reqack), 64'd1);
        @(negedge clk);
        bus.reqcyc = 1'b0;
        for (int i = 0; i < 8; i++) ed[i] = 64'hA0 + 64'(i);
        collect(8, 16'h0022, 0, 1'b1, 1'b0);

        // reset after three data words of a write
        for (int i = 0; i < 8; i++) wd[i] = 64'h7700 + 64'(i);
        do_op(1'b1, 64'h400, 16'h1010, 0, 1'b0);
        send_beat(64'h400, 16'h1011);
        for (int i = 0; i < 3; i++) send_beat(64'h8800 + 64'(i), 16'h1011);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_respcyc", 64'(bus.respcyc), 64'd0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_resp", 64'(bus.respcyc), 64'd0);
        end
        for (int i = 0; i < 3; i++) mdl[16 * 8 + i] = 64'h8800 + 64'(i);
        for (int i = 0; i < 8; i++) ed[i] = mdl[16 * 8 + i];
        do_op(1'b0, 64'h400, 16'h0011, 0, 1'b0);

        // randomized ops against the word-array model
        for (int ln = 0; ln < 16; ln++) begin
            for (int i = 0; i < 8; i++) wd[i] = {$urandom, $urandom};
            do_op(1'b1, 64'(ln) * 64 + 64'($urandom_range(0, 63)),
                  TAG_W'($urandom) | TAG_W'(16'h1000), 2, 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            bit          wr;
            bit          oob;
            int          ln;
            logic [TAG_W-1:0] tg;
            oob = $urandom_range(0, 9) == 0;
            ln  = oob ? LINES + int'($urandom_range(0, 100))
                      : int'($urandom_range(0, 15));
            wr  = 1'($urandom_range(0, 1));
            tg  = TAG_W'($urandom);
            tg[12] = wr;
            for (int i = 0; i < 8; i++) begin
                wd[i] = {$urandom, $urandom};
                ed[i] = oob ? 64'd0 : mdl[ln * 8 + i];
            end
            do_op(wr, 64'(ln) * 64 + 64'($urandom_range(0, 63)), tg,
                  int'($urandom_range(0, 2)), oob);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
